// File: rtl/dmem_ctrl.sv
// Single-port data memory controller with a programmable number of wait states.
// Optional range check on the word address is enabled by defining DMEM_ADDR_CHECK_EN.
module dmem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] dmem_ram_addr,
  input  logic [31:0] dmem_ram_wdata,
  input  logic [3:0]  dmem_ram_be,
  input  logic        dmem_ram_req,
  input  logic        dmem_ram_we,
  output logic [31:0] dmem_ram_rdata,
  output logic        dmem_ram_ready,
  output logic        dmem_ram_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          oob_q, oob_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic          we_q, we_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ready_q, ready_d;
  logic          err_q, err_d;

  logic [31:0]   mem_q [DEPTH_WORDS];

  logic [AW-1:0] in_idx_c;
  logic          in_oob_c;
  logic [AW-1:0] acc_idx_c;
  logic          acc_oob_c;
  logic          acc_we_c;
  logic [31:0]   acc_wdata_c;
  logic [3:0]    acc_be_c;
  logic          access_c;
  logic          mem_wr_c;

  assign in_idx_c = dmem_ram_addr[AW+1:2];

`ifdef DMEM_ADDR_CHECK_EN
  assign in_oob_c = (dmem_ram_addr[31:2] >= 30'(DEPTH_WORDS));
`else
  assign in_oob_c = 1'b0;
`endif

  // Byte offset is meaningless for word accesses; upper bits only matter with the range check.
  logic unused_addr;
  assign unused_addr = ^{dmem_ram_addr[31:AW+2], dmem_ram_addr[1:0]};

  // With zero wait states the array is accessed on the sampling edge, so use the live inputs there.
  always_comb begin
    acc_idx_c   = idx_q;
    acc_oob_c   = oob_q;
    acc_we_c    = we_q;
    acc_wdata_c = wdata_q;
    acc_be_c    = be_q;
    if (state_q == IDLE) begin
      acc_idx_c   = in_idx_c;
      acc_oob_c   = in_oob_c;
      acc_we_c    = dmem_ram_we;
      acc_wdata_c = dmem_ram_wdata;
      acc_be_c    = dmem_ram_be;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    oob_d    = oob_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    we_d     = we_q;
    rdata_d  = rdata_q;
    ready_d  = 1'b0;
    err_d    = 1'b0;
    access_c = 1'b0;
    mem_wr_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (dmem_ram_req) begin
          idx_d   = in_idx_c;
          oob_d   = in_oob_c;
          wdata_d = dmem_ram_wdata;
          be_d    = dmem_ram_be;
          we_d    = dmem_ram_we;
          cnt_d   = CW'(WAIT_STATES);
          state_d = (WAIT_STATES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The array is touched only on the edge that enters RESP.
    access_c = (state_d == RESP) && (state_q != RESP);
    if (access_c) begin
      ready_d = 1'b1;
      err_d   = acc_oob_c;
      if (!acc_we_c) rdata_d = acc_oob_c ? 32'h0 : mem_q[acc_idx_c];
    end
    mem_wr_c = access_c && acc_we_c && !acc_oob_c && rstn;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      oob_q   <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      oob_q   <= oob_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Storage array carries no reset; contents survive rstn.
  always_ff @(posedge clk) begin
    if (mem_wr_c) begin
      for (int n = 0; n < 4; n++) begin
        if (acc_be_c[n]) mem_q[acc_idx_c][8*n +: 8] <= acc_wdata_c[8*n +: 8];
      end
    end
  end

  assign dmem_ram_rdata = rdata_q;
  assign dmem_ram_ready = ready_q;
  assign dmem_ram_err   = err_q;

endmodule
